// File: rtl/strip_buf_pkg.sv
// Shared types and helpers for the double-buffered strip tile buffer.
// Geometry helpers and the bank address map used by both write and read paths.
package strip_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2,
        ACTIVE  = 2'd3
    } bank_state_t;

    // Halo columns on each side of a strip for an odd kernel.
    function automatic int halo_of(input int k);
        return k / 2;
    endfunction

    // Stored strip width including both halos.
    function automatic int sw_of(input int tw, input int k);
        return tw + 2 * (k / 2);
    endfunction

    // Elements held by one bank: all channels, full height, strip width.
    function automatic int depth_of(
        input int nch,
        input int fmh,
        input int tw,
        input int k
    );
        return nch * fmh * sw_of(tw, k);
    endfunction

    // Linear memory address of (bank, ch, y, lx).
    function automatic int buf_addr(
        input int bank,
        input int ch,
        input int y,
        input int lx,
        input int fmh,
        input int sw,
        input int depth
    );
        return bank * depth + (ch * fmh + y) * sw + lx;
    endfunction

endpackage

// File: rtl/strip_tile_buffer_counter.sv
// Nested ch/y/lx beat counter for one strip load.
// Flags the final beat and whether the current column lies inside the map.
module strip_load_counter #(
    parameter int NB_CH     = 2,
    parameter int FM_HEIGHT = 128,
    parameter int FM_WIDTH  = 128,
    parameter int SW        = 66,
    parameter int HALO      = 1,
    parameter int XW        = 8,
    parameter int CHW       = 1,
    parameter int YCW       = 7,
    parameter int LCW       = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic signed [XW-1:0] x0_in,
    output logic [CHW-1:0]       ch,
    output logic [YCW-1:0]       y,
    output logic [LCW-1:0]       lx,
    output logic                 last,
    output logic                 x_ok
);

    localparam int XAW = ((XW > LCW) ? XW : LCW) + 2;
    localparam logic [CHW-1:0] CH_LAST = CHW'(NB_CH - 1);
    localparam logic [YCW-1:0] Y_LAST  = YCW'(FM_HEIGHT - 1);
    localparam logic [LCW-1:0] LX_LAST = LCW'(SW - 1);

    logic signed [XW-1:0]  x0;
    logic signed [XAW-1:0] xabs;

    assign last = (ch == CH_LAST) && (y == Y_LAST) && (lx == LX_LAST);

    // Absolute map column of the current beat; outside the map stores zero.
    assign xabs = XAW'(x0) - XAW'(HALO) + XAW'({1'b0, lx});
    assign x_ok = !xabs[XAW-1] && (xabs < $signed(XAW'(FM_WIDTH)));

    // Counters advance lx fastest, then y, then ch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
            y  <= '0;
            lx <= '0;
            x0 <= '0;
        end else if (clear) begin
            ch <= '0;
            y  <= '0;
            lx <= '0;
            x0 <= x0_in;
        end else if (step) begin
            if (lx == LX_LAST) begin
                lx <= '0;
                if (y == Y_LAST) begin
                    y  <= '0;
                    ch <= (ch == CH_LAST) ? '0 : ch + CHW'(1);
                end else begin
                    y <= y + YCW'(1);
                end
            end else begin
                lx <= lx + LCW'(1);
            end
        end
    end

endmodule

// File: rtl/strip_tile_buffer_mem.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
// Read data appears the cycle after a read enable.
module strip_buf_mem #(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/strip_tile_buffer.sv
// Double-buffered input-strip buffer: one bank loads from the stream
// while the MAC datapath reads the other, with zero padding at map edges.
module strip_tile_buffer
    import strip_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int TILE_W      = 64,
    parameter int FM_WIDTH    = 128,
    parameter int FM_HEIGHT   = 128,
    parameter int NB_CH       = 2,
    parameter int KERNEL_SIZE = 3,
    localparam int HALO       = halo_of(KERNEL_SIZE),
    localparam int SW         = sw_of(TILE_W, KERNEL_SIZE),
    localparam int BANK_DEPTH = depth_of(NB_CH, FM_HEIGHT, TILE_W, KERNEL_SIZE),
    localparam int XW         = $clog2(FM_WIDTH) + 1,
    localparam int YW         = $clog2(FM_HEIGHT) + 1,
    localparam int LXW        = $clog2(SW) + 1,
    localparam int CHW        = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                  clk,
    input  logic                  arst_in,
    input  logic                  load_start,
    input  logic signed [XW-1:0]  load_x0,
    output logic                  load_start_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  load_busy,
    output logic                  tile_avail,
    output logic signed [XW-1:0]  tile_x0,
    input  logic                  tile_release,
    input  logic                  rd_en,
    input  logic [CHW-1:0]        rd_ch,
    input  logic signed [YW-1:0]  rd_y,
    input  logic signed [LXW-1:0] rd_x,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int MEM_DEPTH = 2 * BANK_DEPTH;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int YCW       = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
    localparam int LCW       = (SW > 1) ? $clog2(SW) : 1;

    bank_state_t          st   [2];
    bank_state_t          st_n [2];
    logic signed [XW-1:0] bx0  [2];
    logic                 ld_bank;

    logic any_loading;
    logic any_empty;
    logic any_active;
    logic act_idx;
    logic new_bank;
    logic accept;
    logic fire;
    logic last_fire;
    logic rel;

    logic [CHW-1:0]        w_ch;
    logic [YCW-1:0]        w_y;
    logic [LCW-1:0]        w_lx;
    logic                  w_last;
    logic                  w_xok;
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] wdata;

    int                    ry;
    int                    rx;
    logic                  rd_ok;
    logic [AW-1:0]         raddr;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  zero_q;

    assign any_loading = (st[0] == LOADING) || (st[1] == LOADING);
    assign any_empty   = (st[0] == EMPTY)   || (st[1] == EMPTY);
    assign any_active  = (st[0] == ACTIVE)  || (st[1] == ACTIVE);
    assign act_idx     = (st[1] == ACTIVE);
    assign new_bank    = (st[0] != EMPTY);

    assign load_start_ready = !any_loading && any_empty;
    assign in_ready         = any_loading;
    assign load_busy        = any_loading;
    assign tile_avail       = any_active;

    assign accept    = load_start && load_start_ready;
    assign fire      = in_valid && in_ready;
    assign last_fire = fire && w_last;
    assign rel       = tile_release && any_active;

    // Bank lifecycle: accept, completion, release with same-cycle hand-over,
    // and delayed promotion of a FULL bank when nothing is active.
    always_comb begin
        st_n[0] = st[0];
        st_n[1] = st[1];
        if (accept) begin
            st_n[new_bank] = LOADING;
        end
        if (last_fire) begin
            st_n[ld_bank] = FULL;
        end
        if (rel) begin
            st_n[act_idx] = EMPTY;
            if (st_n[!act_idx] == FULL) begin
                st_n[!act_idx] = ACTIVE;
            end
        end else if (!any_active) begin
            if (st[0] == FULL) begin
                st_n[0] = ACTIVE;
            end else if (st[1] == FULL) begin
                st_n[1] = ACTIVE;
            end
        end
    end

    // Bank state, latched strip origins and the active strip origin.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            st[0]   <= EMPTY;
            st[1]   <= EMPTY;
            bx0[0]  <= '0;
            bx0[1]  <= '0;
            ld_bank <= 1'b0;
            tile_x0 <= '0;
        end else begin
            st[0] <= st_n[0];
            st[1] <= st_n[1];
            if (accept) begin
                ld_bank       <= new_bank;
                bx0[new_bank] <= load_x0;
            end
            if (st_n[0] == ACTIVE) begin
                tile_x0 <= bx0[0];
            end else if (st_n[1] == ACTIVE) begin
                tile_x0 <= bx0[1];
            end
        end
    end

    strip_load_counter #(
        .NB_CH     (NB_CH),
        .FM_HEIGHT (FM_HEIGHT),
        .FM_WIDTH  (FM_WIDTH),
        .SW        (SW),
        .HALO      (HALO),
        .XW        (XW),
        .CHW       (CHW),
        .YCW       (YCW),
        .LCW       (LCW)
    ) u_cnt (
        .clk   (clk),
        .rst   (arst_in),
        .clear (accept),
        .step  (fire),
        .x0_in (load_x0),
        .ch    (w_ch),
        .y     (w_y),
        .lx    (w_lx),
        .last  (w_last),
        .x_ok  (w_xok)
    );

    // Off-map columns are written as zero so reads need no horizontal check.
    assign wdata = w_xok ? in_data : '0;
    assign waddr = AW'(buf_addr(int'(ld_bank), int'(w_ch), int'(w_y),
                                int'(w_lx), FM_HEIGHT, SW, BANK_DEPTH));

    assign ry    = int'(rd_y);
    assign rx    = int'(rd_x);
    assign rd_ok = any_active
                && (ry >= 0) && (ry < FM_HEIGHT)
                && (rx >= -HALO) && (rx <= TILE_W - 1 + HALO);
    assign raddr = AW'(buf_addr(int'(act_idx), int'(rd_ch), ry,
                                rx + HALO, FM_HEIGHT, SW, BANK_DEPTH));

    strip_buf_mem #(
        .DW    (DATA_WIDTH),
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (fire),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_en && rd_ok),
        .raddr (raddr),
        .rdata (mem_q)
    );

    // One-cycle read pipeline; invalid requests return zero.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            rd_valid <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            zero_q   <= !(rd_en && rd_ok);
        end
    end

    assign rd_data = zero_q ? '0 : mem_q;

endmodule
